dmem_port_arbiter: RTL and testbench

//   Shares the single-port data memory between two requesters: port 0 is the CPU

---
 rtl/dmem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU (port 0)
// and the debug loader (port 1). Optional perf counters: define DMEM_ARB_PERF_EN.
module dmem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_gnt0,
    output logic [31:0]       perf_gnt1,
    output logic [31:0]       perf_conflict
`endif
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
            $error("dmem_port_arbiter: MEM_LAT must be within 1..15");
        end
    endgenerate

    state_t     r_state;
    logic       r_last_gnt;
    logic [3:0] r_lat_cnt;
    logic       r_owner;

    state_t     w_next_state;
    logic       w_next_last_gnt;
    logic [3:0] w_next_lat_cnt;
    logic       w_next_owner;
    logic       w_any_req;
    logic       w_winner;

    assign w_any_req = r0_req | r1_req;
    // On conflict the port that did not win last time goes first; a lone request wins outright.
    assign w_winner  = (r0_req && r1_req) ? ~r_last_gnt : r1_req;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
            r_lat_cnt  <= 4'd0;
            r_owner    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_last_gnt <= w_next_last_gnt;
            r_lat_cnt  <= w_next_lat_cnt;
            r_owner    <= w_next_owner;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state    = r_state;
        w_next_last_gnt = r_last_gnt;
        w_next_lat_cnt  = r_lat_cnt;
        w_next_owner    = r_owner;
        r0_gnt          = 1'b0;
        r1_gnt          = 1'b0;
        r0_rvalid       = 1'b0;
        r1_rvalid       = 1'b0;
        r0_rdata        = '0;
        r1_rdata        = '0;
        mem_en          = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;

        unique case (r_state)
            IDLE: begin
                if (w_any_req && reset) begin
                    mem_en          = 1'b1;
                    r0_gnt          = ~w_winner;
                    r1_gnt          = w_winner;
                    mem_we          = w_winner ? r1_we    : r0_we;
                    mem_addr        = w_winner ? r1_addr  : r0_addr;
                    mem_wdata       = w_winner ? r1_wdata : r0_wdata;
                    w_next_last_gnt = w_winner;
                    if (!mem_we) begin
                        w_next_state   = RD_WAIT;
                        w_next_lat_cnt = LAT_INIT;
                        w_next_owner   = w_winner;
                    end
                end
            end
            RD_WAIT: begin
                if (r_lat_cnt == 4'd0) begin
                    r0_rvalid    = ~r_owner;
                    r1_rvalid    = r_owner;
                    r0_rdata     = r_owner ? '0 : mem_rdata;
                    r1_rdata     = r_owner ? mem_rdata : '0;
                    w_next_state = IDLE;
                end else begin
                    w_next_lat_cnt = r_lat_cnt - 4'd1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] r_perf_gnt0;
    logic [31:0] r_perf_gnt1;
    logic [31:0] r_perf_conflict;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_gnt0     <= 32'd0;
            r_perf_gnt1     <= 32'd0;
            r_perf_conflict <= 32'd0;
        end else begin
            if (r0_gnt) r_perf_gnt0 <= r_perf_gnt0 + 32'd1;
            if (r1_gnt) r_perf_gnt1 <= r_perf_gnt1 + 32'd1;
            if (r_state == IDLE && r0_req && r1_req)
                r_perf_conflict <= r_perf_conflict + 32'd1;
        end
    end

    assign perf_gnt0     = r_perf_gnt0;
    assign perf_gnt1     = r_perf_gnt1;
    assign perf_conflict = r_perf_conflict;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: stimulus queues expected grants/read returns
// with their cycle numbers, a negedge monitor pops and compares them.
module tb_dmem_port_arbiter;

    localparam int MEM_LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [31:0] r0_rdata, r1_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_gnt0, perf_gnt1, perf_conflict;
`endif

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1), .perf_conflict(perf_conflict)
`endif
    );

    // Memory model: unwritten word i reads 0xA000+i; read data appears MEM_LAT cycles after mem_en.
    logic [31:0] mem_words [256];
    bit          mem_written [256];
    logic [31:0] rd_word;
    logic [31:0] rd_pipe [MEM_LAT];

    assign rd_word   = mem_written[mem_addr[9:2]] ? mem_words[mem_addr[9:2]]
                                                  : 32'hA000 + 32'(mem_addr[9:2]);
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem_words[mem_addr[9:2]]   <= mem_wdata;
            mem_written[mem_addr[9:2]] <= 1'b1;
        end
        for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= (mem_en && !mem_we) ? rd_word : 32'hDEAD_BEEF;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        bit          is_rd;
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic push_gnt(input int c, input bit p, input bit we,
                            input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        e = '{cyc: c, is_rd: 1'b0, port: p, we: we, addr: addr, data: data};
        exp_q.push_back(e);
    endtask

    task automatic push_rd(input int c, input bit p, input logic [31:0] data);
        exp_t e;
        e = '{cyc: c, is_rd: 1'b1, port: p, we: 1'b0, addr: 32'd0, data: data};
        exp_q.push_back(e);
    endtask

    // Monitor: one event (grant or read return) at most per cycle.
    always @(negedge clk) begin
        if (reset) begin
            check("gnt_exclusive", {31'd0, r0_gnt & r1_gnt}, 32'd0);
            if (!r0_rvalid) check("r0_rdata_zero", r0_rdata, 32'd0);
            if (!r1_rvalid) check("r1_rdata_zero", r1_rdata, 32'd0);
            if (!r0_gnt && !r1_gnt) check("mem_en_quiet", {31'd0, mem_en}, 32'd0);
            if (r0_gnt || r1_gnt || r0_rvalid || r1_rvalid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event at cycle %0d: gnt=%b%b rvalid=%b%b, expected none",
                             cyc, r1_gnt, r0_gnt, r1_rvalid, r0_rvalid);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_cycle", 32'(cyc), 32'(mon_e.cyc));
                    if (mon_e.is_rd) begin
                        check("rvalid_port", {30'd0, r1_rvalid, r0_rvalid},
                              mon_e.port ? 32'd2 : 32'd1);
                        check("rdata", mon_e.port ? r1_rdata : r0_rdata, mon_e.data);
                    end else begin
                        check("gnt_port", {30'd0, r1_gnt, r0_gnt}, mon_e.port ? 32'd2 : 32'd1);
                        check("mem_en", {31'd0, mem_en}, 32'd1);
                        check("mem_we", {31'd0, mem_we}, {31'd0, mon_e.we});
                        check("mem_addr", mem_addr, mon_e.addr);
                        if (mon_e.we) check("mem_wdata", mem_wdata, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r0(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
        r0_req = req; r0_we = we; r0_addr = a; r0_wdata = d;
    endtask

    task automatic set_r1(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
        r1_req = req; r1_we = we; r1_addr = a; r1_wdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int c;

    initial begin
        set_r0(0, 0, 0, 0);
        set_r1(0, 0, 0, 0);
        #2 reset = 1'b1;
        step();

        // Single write from port 0.
        c = cyc;
        push_gnt(c, 0, 1, 32'd88, 32'd30);
        set_r0(1, 1, 32'd88, 32'd30);
        step();
        set_r0(0, 0, 0, 0);

        // Port 0 read of untouched word 80 (index 20): returns at T+MEM_LAT.
        c = cyc;
        push_gnt(c, 0, 0, 32'd80, 32'd0);
        push_rd(c + 3, 0, 32'hA014);
        set_r0(1, 0, 32'd80, 0);
        step();
        set_r0(0, 0, 0, 0);
        repeat (3) step();

        // Port 1 reads back the word written by port 0.
        c = cyc;
        push_gnt(c, 1, 0, 32'd88, 32'd0);
        push_rd(c + 3, 1, 32'd30);
        set_r1(1, 0, 32'd88, 0);
        step();
        set_r1(0, 0, 0, 0);
        repeat (3) step();

        // Both ports write continuously: last winner was port 1, so r0,r1,r0,r1.
        c = cyc;
        for (int i = 0; i < 4; i++)
            push_gnt(c + i, i[0], 1, i[0] ? 32'h200 : 32'h100, i[0] ? 32'hB2 : 32'hA1);
        set_r0(1, 1, 32'h100, 32'hA1);
        set_r1(1, 1, 32'h200, 32'hB2);
        repeat (4) step();
        set_r0(0, 0, 0, 0);
        set_r1(0, 0, 0, 0);
`ifdef DMEM_ARB_PERF_EN
        check("perf_conflict", perf_conflict, 32'd4);
        check("perf_gnt0", perf_gnt0, 32'd4);
        check("perf_gnt1", perf_gnt1, 32'd3);
`endif

        // Port 1 read in flight; port 0 write must wait until after the return.
        c = cyc;
        push_gnt(c, 1, 0, 32'h200, 32'd0);
        push_rd(c + 3, 1, 32'hB2);
        push_gnt(c + 4, 0, 1, 32'h104, 32'h55);
        set_r1(1, 0, 32'h200, 0);
        step();
        set_r1(0, 0, 0, 0);
        set_r0(1, 1, 32'h104, 32'h55);
        repeat (4) step();
        set_r0(0, 0, 0, 0);

        // Port 0 read busy; port 1 raises a write then withdraws it before any grant.
        c = cyc;
        push_gnt(c, 0, 0, 32'h104, 32'd0);
        push_rd(c + 3, 0, 32'h55);
        set_r0(1, 0, 32'h104, 0);
        step();
        set_r0(0, 0, 0, 0);
        set_r1(1, 1, 32'h300, 32'h77);
        step();
        set_r1(0, 0, 0, 0);
        repeat (4) step();

        // Word 0x300 (index 192) must still hold its untouched value.
        c = cyc;
        push_gnt(c, 1, 0, 32'h300, 32'd0);
        push_rd(c + 3, 1, 32'hA0C0);
        set_r1(1, 0, 32'h300, 0);
        step();
        set_r1(0, 0, 0, 0);
        repeat (3) step();

        // Reset one cycle into a read: access abandoned, no rvalid afterwards.
        c = cyc;
        push_gnt(c, 0, 0, 32'd80, 32'd0);
        set_r0(1, 0, 32'd80, 0);
        step();
        set_r0(0, 0, 0, 0);
        reset = 1'b0;
        #1;
        check("rst_outputs",
              {26'd0, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_en, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
`ifdef DMEM_ARB_PERF_EN
        check("rst_perf_conflict", perf_conflict, 32'd0);
        check("rst_perf_gnt0", perf_gnt0, 32'd0);
`endif
        step();
        step();
        reset = 1'b1;
        repeat (6) step();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
